lsu_dmem_if: RTL and testbench

- Load/store unit sitting directly upstream of the word-addressed data memory (dmem).
- Accepts byte-addressed RV32 load/store requests from the core pipeline and converts them into dmem word accesses: word index, byte write mask, lane-shifted write data.
- Formats dmem read data on the way back: byte/halfword extraction, sign/zero extension.
- Faults illegal, misaligned and out-of-range accesses. With the optional feature, it splits misaligned accesses into two word accesses.

---
 rtl/lsu_dmem_if.sv | 203 ++++++++++++++++++++
 tb/tb_lsu_dmem_if.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_dmem_if.sv
// lsu_dmem_if: RV32 load/store unit in front of a word-addressed dmem.
// Define LSU_MISALIGNED_SPLIT_EN to split misaligned H/W into two words.
module lsu_dmem_if #(
  parameter int MEM_SIZE = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_fault,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wmask,
  output logic        mem_we,
  input  logic [31:0] mem_rdata
);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] ACC0 = 3'd1;
  localparam logic [2:0] CAP0 = 3'd2;
`ifdef LSU_MISALIGNED_SPLIT_EN
  localparam logic [2:0] ACC1 = 3'd3;
  localparam logic [2:0] CAP1 = 3'd4;
`endif
  localparam logic [2:0] RESP = 3'd5;

  logic [2:0]  state;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic        r_we;
  logic [2:0]  r_f3;
`ifdef LSU_MISALIGNED_SPLIT_EN
  logic        r_split;
  logic [31:0] lo_buf;
  logic [7:0]  mask8;
  logic [63:0] data64;
`endif

  logic [30:0] q_w0;
  logic        q_ill;
  logic        q_mis;
  logic        q_oor;
  logic        q_bad;
  logic [1:0]  off;
  logic [3:0]  sz;
  logic [3:0]  lo_mask;
  logic [31:0] lo_data;
  logic [31:0] ld_word;
  logic [31:0] ld_fmt;

  // Classify the incoming request before it is accepted
  always_comb begin
    q_w0  = {1'b0, req_addr[31:2]};
    q_ill = req_we
      ? !(req_funct3 inside {3'b000, 3'b001, 3'b010})
      : (req_funct3 inside {3'b011, 3'b110, 3'b111});
    q_mis = (req_funct3[1:0] == 2'b01 && req_addr[0])
         || (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00);
    q_oor = q_w0 >= 31'(MEM_SIZE);
`ifdef LSU_MISALIGNED_SPLIT_EN
    if (q_mis && (q_w0 + 31'd1 >= 31'(MEM_SIZE)))
      q_oor = 1'b1;
    q_bad = q_ill | q_oor;
`else
    q_bad = q_ill | q_mis | q_oor;
`endif
  end

  // Byte-lane placement of store data and load extraction
  always_comb begin
    off = r_addr[1:0];
    unique case (1'b1)
      r_f3[1:0] == 2'b00: sz = 4'b0001;
      r_f3[1:0] == 2'b01: sz = 4'b0011;
      default:            sz = 4'b1111;
    endcase
`ifdef LSU_MISALIGNED_SPLIT_EN
    mask8   = {4'b0, sz} << off;
    data64  = {32'b0, r_wdata} << {off, 3'b000};
    lo_mask = mask8[3:0];
    lo_data = data64[31:0];
    if (state == CAP1)
      ld_word = 32'({mem_rdata, lo_buf} >> {off, 3'b000});
    else
      ld_word = mem_rdata >> {off, 3'b000};
`else
    lo_mask = sz << off;
    lo_data = r_wdata << {off, 3'b000};
    ld_word = mem_rdata >> {off, 3'b000};
`endif
    unique case (1'b1)
      r_f3 == 3'b000: ld_fmt = {{24{ld_word[7]}}, ld_word[7:0]};
      r_f3 == 3'b100: ld_fmt = {24'b0, ld_word[7:0]};
      r_f3 == 3'b001: ld_fmt = {{16{ld_word[15]}}, ld_word[15:0]};
      r_f3 == 3'b101: ld_fmt = {16'b0, ld_word[15:0]};
      default:        ld_fmt = ld_word;
    endcase
  end

  // Drive the dmem port from the current access state
  always_comb begin
    mem_addr  = 32'b0;
    mem_wdata = 32'b0;
    mem_wmask = 4'b0;
    case (state)
      ACC0, CAP0: begin
        mem_addr = {2'b0, r_addr[31:2]};
        if (state == ACC0 && r_we) begin
          mem_wmask = lo_mask;
          mem_wdata = lo_data;
        end
      end
`ifdef LSU_MISALIGNED_SPLIT_EN
      ACC1, CAP1: begin
        mem_addr = {2'b0, r_addr[31:2]} + 32'd1;
        if (state == ACC1 && r_we) begin
          mem_wmask = mask8[7:4];
          mem_wdata = data64[63:32];
        end
      end
`endif
      default: ;
    endcase
`ifdef LSU_MISALIGNED_SPLIT_EN
    mem_we = rst && r_we && (state == ACC0 || state == ACC1);
`else
    mem_we = rst && r_we && (state == ACC0);
`endif
    req_ready  = rst && (state == IDLE);
    resp_valid = rst && (state == RESP);
  end

  // Request capture, access sequencing and response registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      r_addr     <= 32'b0;
      r_wdata    <= 32'b0;
      r_we       <= 1'b0;
      r_f3       <= 3'b0;
      resp_rdata <= 32'b0;
      resp_fault <= 1'b0;
`ifdef LSU_MISALIGNED_SPLIT_EN
      r_split    <= 1'b0;
      lo_buf     <= 32'b0;
`endif
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          r_addr     <= req_addr;
          r_wdata    <= req_wdata;
          r_we       <= req_we;
          r_f3       <= req_funct3;
          resp_rdata <= 32'b0;
          resp_fault <= q_bad;
`ifdef LSU_MISALIGNED_SPLIT_EN
          r_split    <= q_mis;
`endif
          state      <= q_bad ? RESP : ACC0;
        end
        ACC0: begin
`ifdef LSU_MISALIGNED_SPLIT_EN
          if (r_we) state <= r_split ? ACC1 : RESP;
          else      state <= CAP0;
`else
          state <= r_we ? RESP : CAP0;
`endif
        end
        CAP0: begin
`ifdef LSU_MISALIGNED_SPLIT_EN
          if (r_split) begin
            lo_buf <= mem_rdata;
            state  <= ACC1;
          end else begin
            resp_rdata <= ld_fmt;
            state      <= RESP;
          end
`else
          resp_rdata <= ld_fmt;
          state      <= RESP;
`endif
        end
`ifdef LSU_MISALIGNED_SPLIT_EN
        ACC1: state <= r_we ? RESP : CAP1;
        CAP1: begin
          resp_rdata <= ld_fmt;
          state      <= RESP;
        end
`endif
        RESP: if (resp_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_dmem_if.sv
// tb_lsu_dmem_if: directed vectors for lsu_dmem_if against a dmem model.
// Expectations follow LSU_MISALIGNED_SPLIT_EN when it is defined.
module tb_lsu_dmem_if;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'b0;
  logic [31:0] req_addr = 32'b0;
  logic [31:0] req_wdata = 32'b0;
  logic        resp_valid;
  logic        resp_ready = 1'b1;
  logic [31:0] resp_rdata;
  logic        resp_fault;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_we;
  logic [31:0] mem_rdata;

  lsu_dmem_if #(.MEM_SIZE(1024)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_funct3(req_funct3),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_fault(resp_fault),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wmask(mem_wmask), .mem_we(mem_we),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [0:1023];
  int wcnt;

  // dmem model: byte-masked write, one-cycle read
  always @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 1024; i++) mem[i] <= 32'b0;
      wcnt <= 0;
    end else if (mem_we) begin
      for (int b = 0; b < 4; b++)
        if (mem_wmask[b])
          mem[mem_addr[9:0]][8*b +: 8] <= mem_wdata[8*b +: 8];
      wcnt <= wcnt + 1;
    end
    mem_rdata <= mem[mem_addr[9:0]];
  end

  int nvec = 0;
  int nmis = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nmis++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  logic [31:0] t_addr [8];
  logic [31:0] t_wd [8];
  logic [3:0]  t_mask [8];
  logic        t_we [8];
  int          t_n;
  int          lat;
  logic [31:0] r_rd;
  logic        r_ft;
  int          w0;

  task automatic xfer(input logic we, input logic [2:0] f3,
                      input logic [31:0] addr, input logic [31:0] wd);
    @(negedge clk);
    req_we = we; req_funct3 = f3;
    req_addr = addr; req_wdata = wd;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1; t_n = 0;
    while (!resp_valid && lat < 12) begin
      if (t_n < 8) begin
        t_addr[t_n] = mem_addr; t_wd[t_n] = mem_wdata;
        t_mask[t_n] = mem_wmask; t_we[t_n] = mem_we;
      end
      t_n++;
      @(posedge clk); #1;
      lat++;
    end
    if (!resp_valid) check("timeout", {31'b0, resp_valid}, 32'd1);
    r_rd = resp_rdata;
    r_ft = resp_fault;
    @(posedge clk); #1;
  endtask

  task automatic load(input string tag, input logic [2:0] f3,
                      input logic [31:0] addr, input logic [31:0] exp);
    xfer(1'b0, f3, addr, 32'b0);
    check(tag, r_rd, exp);
    check({tag, "_flt"}, {31'b0, r_ft}, 32'd0);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    // reset with a request pending
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010;
    req_addr = 32'h0; req_wdata = 32'hFFFF_FFFF;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      check("rst_rdy", {31'b0, req_ready}, 32'd0);
      check("rst_vld", {31'b0, resp_valid}, 32'd0);
      check("rst_we", {31'b0, mem_we}, 32'd0);
    end
    check("rst_rd", resp_rdata, 32'd0);
    check("rst_flt", {31'b0, resp_fault}, 32'd0);
    @(negedge clk);
    req_valid = 1'b0; rst = 1'b1;
    #1;
    check("rel_rdy", {31'b0, req_ready}, 32'd1);
    load("rst_nowr", 3'b010, 32'h0, 32'h0);

    // SB at byte 2 of word 1
    xfer(1'b1, 3'b000, 32'h6, 32'h0000_00A5);
    check("sb_lat", lat, 32'd2);
    check("sb_flt", {31'b0, r_ft}, 32'd0);
    check("sb_rd", r_rd, 32'd0);
    check("sb_addr", t_addr[0], 32'd1);
    check("sb_mask", {28'b0, t_mask[0]}, 32'b0100);
    check("sb_lane", {24'b0, t_wd[0][23:16]}, 32'hA5);
    check("sb_we", {31'b0, t_we[0]}, 32'd1);
    check("sb_mem", mem[1], 32'h00A5_0000);

    // word 1 = 80FF1234, then byte/half/word loads
    xfer(1'b1, 3'b010, 32'h4, 32'h80FF_1234);
    check("sw_mem", mem[1], 32'h80FF_1234);
    load("lb7", 3'b000, 32'h7, 32'hFFFF_FF80);
    check("ld_lat", lat, 32'd3);
    load("lbu7", 3'b100, 32'h7, 32'h0000_0080);
    load("lh4", 3'b001, 32'h4, 32'h0000_1234);
    load("lh6", 3'b001, 32'h6, 32'hFFFF_80FF);
    load("lhu6", 3'b101, 32'h6, 32'h0000_80FF);
    load("lb5", 3'b000, 32'h5, 32'h0000_0012);
    load("lw4", 3'b010, 32'h4, 32'h80FF_1234);

    // faults
    w0 = wcnt;
    xfer(1'b0, 3'b010, 32'h1000, 32'h0);
    check("oor_flt", {31'b0, r_ft}, 32'd1);
    check("oor_lat", lat, 32'd1);
    check("oor_rd", r_rd, 32'd0);
    xfer(1'b0, 3'b011, 32'h4, 32'h0);
    check("f011_flt", {31'b0, r_ft}, 32'd1);
    xfer(1'b1, 3'b100, 32'h4, 32'h5555_5555);
    check("sh100_flt", {31'b0, r_ft}, 32'd1);
    xfer(1'b1, 3'b000, 32'h1001, 32'h77);
    check("sboor_flt", {31'b0, r_ft}, 32'd1);
    check("flt_nowr", wcnt, w0);
    check("flt_mem", mem[1], 32'h80FF_1234);

    // top word is in range
    xfer(1'b1, 3'b010, 32'hFFC, 32'h1234_5678);
    check("top_flt", {31'b0, r_ft}, 32'd0);
    load("top_lw", 3'b010, 32'hFFC, 32'h1234_5678);

    // split accesses
    xfer(1'b1, 3'b010, 32'h8, 32'h4433_2211);
    xfer(1'b1, 3'b010, 32'hC, 32'h8877_6655);
    xfer(1'b0, 3'b010, 32'hA, 32'h0);
`ifdef LSU_MISALIGNED_SPLIT_EN
    check("slw_flt", {31'b0, r_ft}, 32'd0);
    check("slw_rd", r_rd, 32'h6655_4433);
    check("slw_lat", lat, 32'd5);
    check("slw_a0", t_addr[0], 32'd2);
    check("slw_a1", t_addr[2], 32'd3);
`else
    check("slw_flt", {31'b0, r_ft}, 32'd1);
    check("slw_lat", lat, 32'd1);
    check("slw_rd", r_rd, 32'd0);
`endif
    w0 = wcnt;
    xfer(1'b1, 3'b010, 32'hB, 32'hDEAD_BEEF);
`ifdef LSU_MISALIGNED_SPLIT_EN
    check("ssw_flt", {31'b0, r_ft}, 32'd0);
    check("ssw_lat", lat, 32'd3);
    check("ssw_a0", t_addr[0], 32'd2);
    check("ssw_m0", {28'b0, t_mask[0]}, 32'b1000);
    check("ssw_a1", t_addr[1], 32'd3);
    check("ssw_m1", {28'b0, t_mask[1]}, 32'b0111);
    check("ssw_w2", mem[2], 32'hEF33_2211);
    check("ssw_w3", mem[3], 32'h88DE_ADBE);
    xfer(1'b0, 3'b001, 32'h9, 32'h0);
    check("slh_rd", r_rd, 32'h0000_3322);
    check("slh_lat", lat, 32'd5);
`else
    check("ssw_flt", {31'b0, r_ft}, 32'd1);
    check("ssw_nowr", wcnt, w0);
    check("ssw_w2", mem[2], 32'h4433_2211);
    check("ssw_w3", mem[3], 32'h8877_6655);
    xfer(1'b0, 3'b001, 32'h9, 32'h0);
    check("slh_flt", {31'b0, r_ft}, 32'd1);
`endif
    xfer(1'b0, 3'b010, 32'hFFE, 32'h0);
    check("sedge_flt", {31'b0, r_ft}, 32'd1);

    // backpressure on the response
    resp_ready = 1'b0;
    @(negedge clk);
    req_we = 1'b0; req_funct3 = 3'b010;
    req_addr = 32'h4; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 12) begin
      @(posedge clk); #1;
      lat++;
    end
    check("bp_lat", lat, 32'd3);
    @(negedge clk);
    req_we = 1'b1; req_funct3 = 3'b010;
    req_addr = 32'h10; req_wdata = 32'h1;
    req_valid = 1'b1;
    w0 = wcnt;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check("bp_vld", {31'b0, resp_valid}, 32'd1);
      check("bp_rd", resp_rdata, 32'h80FF_1234);
      check("bp_flt", {31'b0, resp_fault}, 32'd0);
      check("bp_rdy", {31'b0, req_ready}, 32'd0);
    end
    @(negedge clk);
    req_valid = 1'b0;
    resp_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_done", {31'b0, resp_valid}, 32'd0);
    check("bp_idle", {31'b0, req_ready}, 32'd1);
    check("bp_nowr", wcnt, w0);
    check("bp_mem", mem[4], 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
